// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : FSM state encoding (IDLE / SHIFT / DONE)
//   fs_borrow : borrow-out of a one-bit full subtractor
//   fs_diff   : difference bit of a one-bit full subtractor
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit combinational full subtractor: d = a - b - bin, bo = borrow out.
// Ports:
//   a, b, bin : operand bits and borrow in
//   d         : difference bit
//   bo        : borrow out
module fs_bit
    import sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = fs_diff(a, b, bin);
    assign bo = fs_borrow(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, one bit per clock,
// LSB first, with a start/busy/done handshake.
// Ports:
//   clk, rst : clock (rising edge), synchronous active-high reset
//   start    : capture a/b/bin and begin (only honoured in IDLE)
//   a, b     : minuend, subtrahend
//   bin      : borrow into bit 0
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when diff/bout/ovf are valid
//   diff     : difference (partial while busy, held from done until next start)
//   bout     : borrow out of the MSB
//   ovf      : signed two's complement overflow
module serial_subtractor
    import sub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               a_msb;
    logic               b_msb;
    logic               d_bit;
    logic               bo_bit;
    logic               last_bit;

    fs_bit u_fs (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (br),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // bout/ovf are registered on the final shift edge so they are already
    // valid during the DONE cycle; the final difference bit is d_bit itself,
    // which becomes diff[WIDTH-1] on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    br   <= bo_bit;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        bout <= bo_bit;
                        ovf  <= (a_msb != b_msb) & (d_bit != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       s8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       s3, bin3, busy3, done3, bout3, ovf3;
    logic [2:0] a3, b3, diff3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives a start for one cycle and waits for done. lat counts edges from
    // the cycle start was driven to the cycle done is seen.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int lat, output int bcnt);
        @(posedge clk); #1;
        s8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        lat = 0; bcnt = 0;
        while (lat < 64) begin
            @(posedge clk); #1;
            s8 = 1'b0; a8 = 8'h55; b8 = 8'hAA; bin8 = 1'b1;
            lat++;
            if (busy8) bcnt++;
            if (done8) break;
        end
        check("op8_done_seen", 32'(done8), 32'd1);
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic bin,
                       output int lat, output int bcnt);
        @(posedge clk); #1;
        s3 = 1'b1; a3 = a; b3 = b; bin3 = bin;
        lat = 0; bcnt = 0;
        while (lat < 32) begin
            @(posedge clk); #1;
            s3 = 1'b0; a3 = ~a; b3 = ~b; bin3 = ~bin;
            lat++;
            if (busy3) bcnt++;
            if (done3) break;
        end
        check("op3_done_seen", 32'(done3), 32'd1);
    endtask

    initial begin
        vec_t vecs[9];
        int lat, bcnt, dseen;
        logic [2:0] ed;
        logic eb, eo;

        vecs[0] = '{8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};
        vecs[8] = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1};

        rst = 1'b1;
        s8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        s3 = 0; a3 = 0; b3 = 0; bin3 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_diff", 32'(diff8), 0);
        check("rst_bout", 32'(bout8), 0);
        check("rst_ovf",  32'(ovf8), 0);

        // table-driven vectors at WIDTH=8
        for (int unsigned i = 0; i < 9; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bcnt);
            check($sformatf("v%0d_diff", i), 32'(diff8), 32'(vecs[i].diff));
            check($sformatf("v%0d_bout", i), 32'(bout8), 32'(vecs[i].bout));
            check($sformatf("v%0d_ovf", i),  32'(ovf8),  32'(vecs[i].ovf));
            check($sformatf("v%0d_lat", i),  32'(lat), 32'd9);
            check($sformatf("v%0d_busy", i), 32'(bcnt), 32'd8);
            @(posedge clk); #1;
            check($sformatf("v%0d_pulse", i), 32'(done8), 0);
            check($sformatf("v%0d_hold", i), 32'(diff8), 32'(vecs[i].diff));
        end

        // start while busy is ignored
        @(posedge clk); #1;
        s8 = 1; a8 = 8'd50; b8 = 8'd20; bin8 = 0;
        @(posedge clk); #1; s8 = 0;
        @(posedge clk); #1; @(posedge clk); #1;
        s8 = 1; a8 = 8'd1; b8 = 8'd1;
        @(posedge clk); #1; s8 = 0;
        lat = 0;
        while (!done8 && lat < 32) begin @(posedge clk); #1; lat++; end
        check("ign_done", 32'(done8), 1);
        check("ign_diff", 32'(diff8), 32'd30);
        // start in DONE cycle is ignored too
        s8 = 1; a8 = 8'd9; b8 = 8'd2;
        @(posedge clk); #1; s8 = 0;
        @(posedge clk); #1;
        check("done_start_ign", 32'(busy8), 0);

        // reset mid-operation abandons the op
        s8 = 1; a8 = 8'd90; b8 = 8'd3; bin8 = 0;
        @(posedge clk); #1; s8 = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1; rst = 0;
        check("mid_rst_busy", 32'(busy8), 0);
        check("mid_rst_diff", 32'(diff8), 0);
        check("mid_rst_bout", 32'(bout8), 0);
        check("mid_rst_ovf",  32'(ovf8), 0);
        dseen = 0;
        repeat (12) begin @(posedge clk); #1; if (done8 || busy8) dseen++; end
        check("mid_rst_nodone", 32'(dseen), 0);

        // start together with rst: rst wins
        s8 = 1; rst = 1; a8 = 8'd7; b8 = 8'd1;
        @(posedge clk); #1; s8 = 0; rst = 0;
        check("rst_start_busy", 32'(busy8), 0);
        @(posedge clk); #1;
        check("rst_start_busy2", 32'(busy8), 0);

        // exhaustive sweep at WIDTH=3
        for (int unsigned ai = 0; ai < 8; ai++) begin
            for (int unsigned bi = 0; bi < 8; bi++) begin
                for (int unsigned ci = 0; ci < 2; ci++) begin
                    ed = 3'(ai - bi - ci);
                    eb = (ai < bi + ci);
                    eo = (ai[2] != bi[2]) && (ed[2] != ai[2]);
                    op3(3'(ai), 3'(bi), ci[0], lat, bcnt);
                    check($sformatf("sw_%0d_%0d_%0d_diff", ai, bi, ci), 32'(diff3), 32'(ed));
                    check($sformatf("sw_%0d_%0d_%0d_bout", ai, bi, ci), 32'(bout3), 32'(eb));
                    check($sformatf("sw_%0d_%0d_%0d_ovf", ai, bi, ci),  32'(ovf3), 32'(eo));
                    check($sformatf("sw_%0d_%0d_%0d_lat", ai, bi, ci),  32'(lat), 32'd4);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
